// File: rtl/trig_lut_pipe.sv
// trig_lut_pipe: two-stage pipelined sin/cos lookup for integer degrees -180..179,
// folded onto one quarter-wave table. Define TRIG_LUT_SIGNED_OUT_EN for the signed outputs.
module trig_lut_pipe #(
  parameter int VAL_WIDTH   = 16,
  parameter int ANGLE_WIDTH = 9,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [ANGLE_WIDTH-1:0] angle_in,
  input  logic [TAG_WIDTH-1:0]   tag_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [VAL_WIDTH-1:0]   sin_mag_out,
  output logic                   sin_neg_out,
  output logic [VAL_WIDTH-1:0]   cos_mag_out,
  output logic                   cos_neg_out,
  output logic [TAG_WIDTH-1:0]   tag_out,
  output logic                   range_err_out,
`ifdef TRIG_LUT_SIGNED_OUT_EN
  output logic [VAL_WIDTH:0]     sin_s_out,
  output logic [VAL_WIDTH:0]     cos_s_out,
`endif
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int QW_LAST   = 90;
  localparam int IDX_WIDTH = 7;
  localparam logic signed [ANGLE_WIDTH:0] DEG_90  = (ANGLE_WIDTH+1)'(90);
  localparam logic signed [ANGLE_WIDTH:0] DEG_180 = (ANGLE_WIDTH+1)'(180);
  localparam real PI = 3.14159265358979323846;

  // The tiny bias keeps the exact-half case (sin 30) rounding up despite double error.
  function automatic logic [VAL_WIDTH-1:0] quarter_sin(input int k);
    real r;
    r = $sin(real'(k) * PI / 180.0) * (2.0 ** VAL_WIDTH - 1.0) + 0.5 + 1.0e-9;
    return VAL_WIDTH'($rtoi(r));
  endfunction

  logic [VAL_WIDTH-1:0] quarter [0:QW_LAST];

  for (genvar k = 0; k <= QW_LAST; k++) begin : g_quarter
    assign quarter[k] = quarter_sin(k);
  end

  logic                        advance;
  logic                        a_neg;
  logic signed [ANGLE_WIDTH:0] a_ext;
  logic signed [ANGLE_WIDTH:0] m;
  logic                        fold_err;
  logic [IDX_WIDTH-1:0]        fold_sin_idx;
  logic [IDX_WIDTH-1:0]        fold_cos_idx;
  logic                        fold_sin_neg;
  logic                        fold_cos_neg;

  logic                        s1_valid;
  logic [IDX_WIDTH-1:0]        s1_sin_idx;
  logic [IDX_WIDTH-1:0]        s1_cos_idx;
  logic                        s1_sin_neg;
  logic                        s1_cos_neg;
  logic                        s1_err;
  logic [TAG_WIDTH-1:0]        s1_tag;

  logic [VAL_WIDTH-1:0]        sin_val;
  logic [VAL_WIDTH-1:0]        cos_val;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst_in;

  // m carries one extra bit so negating the most negative input cannot wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    a_neg        = angle_in[ANGLE_WIDTH-1];
    a_ext        = {a_neg, angle_in};
    m            = a_neg ? -a_ext : a_ext;
    fold_err     = (m > DEG_180) || ((m == DEG_180) && !a_neg);
    fold_sin_idx = '0;
    fold_cos_idx = '0;
    fold_sin_neg = 1'b0;
    fold_cos_neg = 1'b0;
    if (!fold_err) begin
      fold_sin_neg = a_neg;
      if (m <= DEG_90) begin
        fold_sin_idx = IDX_WIDTH'(m);
        fold_cos_idx = IDX_WIDTH'(DEG_90 - m);
      end else begin
        fold_sin_idx = IDX_WIDTH'(DEG_180 - m);
        fold_cos_idx = IDX_WIDTH'(m - DEG_90);
        fold_cos_neg = 1'b1;
      end
    end
  end

  assign sin_val = quarter[s1_sin_idx];
  assign cos_val = quarter[s1_cos_idx];

  // Both stages move together on advance; a stalled output freezes stage 1 as well.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (rst_in) begin
      s1_valid      <= 1'b0;
      s1_sin_idx    <= '0;
      s1_cos_idx    <= '0;
      s1_sin_neg    <= 1'b0;
      s1_cos_neg    <= 1'b0;
      s1_err        <= 1'b0;
      s1_tag        <= '0;
      out_valid     <= 1'b0;
      sin_mag_out   <= '0;
      sin_neg_out   <= 1'b0;
      cos_mag_out   <= '0;
      cos_neg_out   <= 1'b0;
      tag_out       <= '0;
      range_err_out <= 1'b0;
`ifdef TRIG_LUT_SIGNED_OUT_EN
      sin_s_out     <= '0;
      cos_s_out     <= '0;
`endif
    end else if (advance) begin
      // Outside reset in_ready equals advance, so in_valid alone marks an accept.
      s1_valid      <= in_valid;
      s1_sin_idx    <= fold_sin_idx;
      s1_cos_idx    <= fold_cos_idx;
      s1_sin_neg    <= fold_sin_neg;
      s1_cos_neg    <= fold_cos_neg;
      s1_err        <= fold_err;
      s1_tag        <= tag_in;
      out_valid     <= s1_valid;
      sin_mag_out   <= sin_val;
      sin_neg_out   <= s1_sin_neg && (sin_val != '0);
      cos_mag_out   <= cos_val;
      cos_neg_out   <= s1_cos_neg && (cos_val != '0);
      tag_out       <= s1_tag;
      range_err_out <= s1_err;
`ifdef TRIG_LUT_SIGNED_OUT_EN
      sin_s_out     <= s1_sin_neg ? -{1'b0, sin_val} : {1'b0, sin_val};
      cos_s_out     <= s1_cos_neg ? -{1'b0, cos_val} : {1'b0, cos_val};
`endif
    end
  end

endmodule

// File: tb/tb_trig_lut_pipe.sv
// tb_trig_lut_pipe: directed vectors with hand-computed values for trig_lut_pipe
// (default parameters); signed outputs are checked when TRIG_LUT_SIGNED_OUT_EN is defined.
module tb_trig_lut_pipe;

  localparam int VW = 16;
  localparam int AW = 9;
  localparam int TW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [AW-1:0] angle_in = '0;
  logic [TW-1:0] tag_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] sin_mag_out;
  logic          sin_neg_out;
  logic [VW-1:0] cos_mag_out;
  logic          cos_neg_out;
  logic [TW-1:0] tag_out;
  logic          range_err_out;
`ifdef TRIG_LUT_SIGNED_OUT_EN
  logic [VW:0]   sin_s_out;
  logic [VW:0]   cos_s_out;
`endif
  logic          out_valid;
  logic          out_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic signed [15:0] ang;
    logic [3:0]         tag;
    logic [15:0]        smag;
    logic               sneg;
    logic [15:0]        cmag;
    logic               cneg;
    logic               err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk_in = ~clk_in;

  trig_lut_pipe #(.VAL_WIDTH(VW), .ANGLE_WIDTH(AW), .TAG_WIDTH(TW)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .angle_in      (angle_in),
    .tag_in        (tag_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sin_mag_out   (sin_mag_out),
    .sin_neg_out   (sin_neg_out),
    .cos_mag_out   (cos_mag_out),
    .cos_neg_out   (cos_neg_out),
    .tag_out       (tag_out),
    .range_err_out (range_err_out),
`ifdef TRIG_LUT_SIGNED_OUT_EN
    .sin_s_out     (sin_s_out),
    .cos_s_out     (cos_s_out),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input int ang, input int tag, input logic vld);
    angle_in = AW'(ang);
    tag_in   = TW'(tag);
    in_valid = vld;
  endtask

  task automatic expect_out(input string name, input int smag, input int sneg,
                            input int cmag, input int cneg, input int tag, input int err);
    check({name, ".valid"}, 32'(out_valid), 1);
    check({name, ".sin_mag"}, 32'(sin_mag_out), smag);
    check({name, ".sin_neg"}, 32'(sin_neg_out), sneg);
    check({name, ".cos_mag"}, 32'(cos_mag_out), cmag);
    check({name, ".cos_neg"}, 32'(cos_neg_out), cneg);
    check({name, ".tag"}, 32'(tag_out), tag);
    check({name, ".err"}, 32'(range_err_out), err);
`ifdef TRIG_LUT_SIGNED_OUT_EN
    check({name, ".sin_s"}, 32'($signed(sin_s_out)), (sneg != 0) ? -smag : smag);
    check({name, ".cos_s"}, 32'($signed(cos_s_out)), (cneg != 0) ? -cmag : cmag);
`endif
  endtask

  task automatic add_vec(input int ang, input int tag, input int smag, input int sneg,
                         input int cmag, input int cneg, input int err);
    vec_t v;
    v.ang  = 16'(ang);
    v.tag  = 4'(tag);
    v.smag = 16'(smag);
    v.sneg = 1'(sneg);
    v.cmag = 16'(cmag);
    v.cneg = 1'(cneg);
    v.err  = 1'(err);
    vecs.push_back(v);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst.valid", 32'(out_valid), 0);
    check("rst.in_ready", 32'(in_ready), 0);
    check("rst.sin_mag", 32'(sin_mag_out), 0);
    check("rst.cos_mag", 32'(cos_mag_out), 0);
    check("rst.tag", 32'(tag_out), 0);
    check("rst.err", 32'(range_err_out), 0);
    rst_in = 1'b0;
    #1;
    check("rst.in_ready_after", 32'(in_ready), 1);

    // Single sample, two-cycle latency
    drive(30, 3, 1'b1);
    tick();
    drive(0, 0, 1'b0);
    check("lat.cycle1_valid", 32'(out_valid), 0);
    tick();
    expect_out("lat30", 32768, 0, 56755, 0, 3, 0);
    tick();
    check("lat.idle", 32'(out_valid), 0);

    // Back-to-back stream including range errors and fold boundaries
    add_vec(-90,  1, 65535, 1, 0,     0, 0);
    add_vec(150,  2, 32768, 0, 56755, 1, 0);
    add_vec(-180, 5, 0,     0, 65535, 1, 0);
    add_vec(200,  6, 0,     0, 0,     0, 1);
    add_vec(-181, 7, 0,     0, 0,     0, 1);
    add_vec(179,  8, 1144,  0, 65525, 1, 0);
    add_vec(180,  9, 0,     0, 0,     0, 1);
    add_vec(-256, 10, 0,    0, 0,     0, 1);
    add_vec(-30,  11, 32768, 1, 56755, 0, 0);
    add_vec(90,   12, 65535, 0, 0,     0, 0);
    add_vec(-45,  13, 46340, 1, 46340, 0, 0);
    add_vec(120,  14, 56755, 0, 32768, 1, 0);
    for (int i = 0; i <= vecs.size(); i++) begin
      if (i < vecs.size()) drive(int'(vecs[i].ang), int'(vecs[i].tag), 1'b1);
      else drive(0, 0, 1'b0);
      tick();
      if (i == 0) begin
        check("stream.first_valid", 32'(out_valid), 0);
      end else begin
        expect_out($sformatf("stream%0d_ang%0d", i - 1, vecs[i-1].ang),
                   int'(vecs[i-1].smag), int'(vecs[i-1].sneg), int'(vecs[i-1].cmag),
                   int'(vecs[i-1].cneg), int'(vecs[i-1].tag), int'(vecs[i-1].err));
      end
    end
    tick();
    check("stream.idle", 32'(out_valid), 0);

    // Backpressure: out_ready low for three edges mid-stream
    drive(0, 0, 1'b1);
    tick();
    drive(1, 1, 1'b1);
    tick();
    expect_out("stall.a0", 0, 0, 65535, 0, 0, 0);
    out_ready = 1'b0;
    drive(2, 2, 1'b1);
    #1;
    check("stall.in_ready_low", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("stall.hold%0d", i), 0, 0, 65535, 0, 0, 0);
      check($sformatf("stall.in_ready%0d", i), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check("stall.in_ready_back", 32'(in_ready), 1);
    tick();
    expect_out("stall.a1", 1144, 0, 65525, 0, 1, 0);
    drive(3, 3, 1'b1);
    tick();
    expect_out("stall.a2", 2287, 0, 65495, 0, 2, 0);
    drive(0, 0, 1'b0);
    tick();
    expect_out("stall.a3", 3430, 0, 65445, 0, 3, 0);
    tick();
    check("stall.idle", 32'(out_valid), 0);

    // Reset with two samples in flight
    drive(45, 1, 1'b1);
    tick();
    drive(60, 2, 1'b1);
    tick();
    expect_out("rst2.pre", 46340, 0, 46340, 0, 1, 0);
    rst_in = 1'b1;
    drive(0, 0, 1'b0);
    #1;
    check("rst2.in_ready", 32'(in_ready), 0);
    tick();
    rst_in = 1'b0;
    check("rst2.valid", 32'(out_valid), 0);
    check("rst2.sin_mag", 32'(sin_mag_out), 0);
    check("rst2.cos_mag", 32'(cos_mag_out), 0);
    check("rst2.tag", 32'(tag_out), 0);
    drive(90, 12, 1'b1);
    tick();
    drive(0, 0, 1'b0);
    check("rst2.no_stale", 32'(out_valid), 0);
    tick();
    expect_out("rst2.post", 65535, 0, 0, 0, 12, 0);
    tick();
    check("rst2.idle", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
